// File: rtl/ob_pkg.sv
// Shared types for the market-order execution sequencer.
// Trade kinds, FSM states and the trade report bundle.
package ob_pkg;

   localparam int OB_QTY_W = 16;
   localparam int OB_UID_W = 10;

   typedef enum logic [1:0] {
      LB_MS = 2'd0,
      LS_MB = 2'd1,
      MS_MB = 2'd2,
      RSVD  = 2'd3
   } trade_type_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      EXEC = 2'd2,
      EMIT = 2'd3
   } exec_state_t;

   typedef struct packed {
      trade_type_t           trade_type;
      logic [OB_QTY_W-1:0]   qty;
      logic [OB_UID_W-1:0]   buy_uid;
      logic [OB_UID_W-1:0]   sell_uid;
   } exec_rpt_t;

endpackage

// File: rtl/ob_fill_calc.sv
// Fill quantity, pop/update selection and residual for one trade.
// Purely combinational; a zero-quantity side never causes an update.
module ob_fill_calc #(
   parameter int QTY_W = 16
) (
   input  logic [QTY_W-1:0] qb,
   input  logic [QTY_W-1:0] qs,
   output logic [QTY_W-1:0] fill,
   output logic             buy_pop,
   output logic             sell_pop,
   output logic             buy_upd,
   output logic             sell_upd,
   output logic [QTY_W-1:0] resid
);

   always_comb begin
      fill     = (qb < qs) ? qb : qs;
      buy_pop  = (qb <= qs);
      sell_pop = (qs <= qb);
      // Zero fill means one side was empty: drop it, leave the other untouched.
      buy_upd  = (qb > qs) && (qs != '0);
      sell_upd = (qs > qb) && (qb != '0);
      resid    = '0;
      if (buy_upd)
         resid = qb - qs;
      else if (sell_upd)
         resid = qs - qb;
   end

endmodule

// File: rtl/ob_cntrl_mk_exec.sv
// Market-order trade sequencer: query, capture, fill, strobe, report.
// One trade in flight at a time; strobes exist only in EXEC.
module ob_cntrl_mk_exec
   import ob_pkg::*;
#(
   parameter int QTY_W = 16,
   parameter int UID_W = 10,
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   output logic             trade_qry,
   input  logic             trade_vld_r,
   input  logic [1:0]       trade_type_r,
   input  logic [QTY_W-1:0] lm_bid_qty,
   input  logic [QTY_W-1:0] lm_ask_qty,
   input  logic [UID_W-1:0] lm_bid_uid,
   input  logic [UID_W-1:0] lm_ask_uid,
   input  logic [QTY_W-1:0] mk_buy_qty,
   input  logic [QTY_W-1:0] mk_sell_qty,
   input  logic [UID_W-1:0] mk_buy_uid,
   input  logic [UID_W-1:0] mk_sell_uid,
   output logic             lm_bid_pop,
   output logic             lm_ask_pop,
   output logic             mk_buy_pop,
   output logic             mk_sell_pop,
   output logic             lm_bid_upd,
   output logic             lm_ask_upd,
   output logic             mk_buy_upd,
   output logic             mk_sell_upd,
   output logic [QTY_W-1:0] upd_qty,
   output logic             rpt_vld,
   input  logic             rpt_accept,
   output logic [1:0]       rpt_type,
   output logic [QTY_W-1:0] rpt_qty,
   output logic [UID_W-1:0] rpt_buy_uid,
   output logic [UID_W-1:0] rpt_sell_uid,
   output logic             busy,
   output logic [CNT_W-1:0] trade_cnt_r
);

   exec_state_t state, state_nxt;
   trade_type_t in_type, cap_type;

   logic [QTY_W-1:0] sel_qb, sel_qs, cap_qb, cap_qs;
   logic [UID_W-1:0] sel_ub, sel_us, cap_ub, cap_us;
   logic [QTY_W-1:0] fill, resid;
   logic             buy_pop, sell_pop, buy_upd, sell_upd;
   logic             cap_load, rpt_load, cnt_inc;
   exec_rpt_t        rpt_r;

   assign in_type = trade_type_t'(trade_type_r);

   always_comb begin
      sel_qb = mk_buy_qty;
      sel_ub = mk_buy_uid;
      sel_qs = mk_sell_qty;
      sel_us = mk_sell_uid;
      unique case (1'b1)
         (in_type == LB_MS): begin
            sel_qb = lm_bid_qty;
            sel_ub = lm_bid_uid;
         end
         (in_type == LS_MB): begin
            sel_qs = lm_ask_qty;
            sel_us = lm_ask_uid;
         end
         default: ;
      endcase
   end

   ob_fill_calc #(.QTY_W(QTY_W)) u_fill (
      .qb       (cap_qb),
      .qs       (cap_qs),
      .fill     (fill),
      .buy_pop  (buy_pop),
      .sell_pop (sell_pop),
      .buy_upd  (buy_upd),
      .sell_upd (sell_upd),
      .resid    (resid)
   );

   always_comb begin
      state_nxt   = state;
      trade_qry   = 1'b0;
      lm_bid_pop  = 1'b0;
      lm_ask_pop  = 1'b0;
      mk_buy_pop  = 1'b0;
      mk_sell_pop = 1'b0;
      lm_bid_upd  = 1'b0;
      lm_ask_upd  = 1'b0;
      mk_buy_upd  = 1'b0;
      mk_sell_upd = 1'b0;
      upd_qty     = '0;
      rpt_vld     = 1'b0;
      busy        = 1'b0;
      cap_load    = 1'b0;
      rpt_load    = 1'b0;
      cnt_inc     = 1'b0;
      // Reset gates every output so nothing leaks in the reset cycle.
      if (!rst) begin
         busy = (state != IDLE);
         unique case (state)
            IDLE: begin
               if (en) begin
                  trade_qry = 1'b1;
                  state_nxt = WAIT;
               end
            end
            WAIT: begin
               state_nxt = IDLE;
               if (trade_vld_r && in_type != RSVD) begin
                  cap_load  = 1'b1;
                  state_nxt = EXEC;
               end
            end
            EXEC: begin
               upd_qty = resid;
               unique case (1'b1)
                  (cap_type == LB_MS): begin
                     lm_bid_pop  = buy_pop;
                     lm_bid_upd  = buy_upd;
                     mk_sell_pop = sell_pop;
                     mk_sell_upd = sell_upd;
                  end
                  (cap_type == LS_MB): begin
                     mk_buy_pop = buy_pop;
                     mk_buy_upd = buy_upd;
                     lm_ask_pop = sell_pop;
                     lm_ask_upd = sell_upd;
                  end
                  default: begin
                     mk_buy_pop  = buy_pop;
                     mk_buy_upd  = buy_upd;
                     mk_sell_pop = sell_pop;
                     mk_sell_upd = sell_upd;
                  end
               endcase
               rpt_load  = (fill != '0);
               state_nxt = (fill != '0) ? EMIT : IDLE;
            end
            EMIT: begin
               rpt_vld = 1'b1;
               if (rpt_accept) begin
                  cnt_inc   = 1'b1;
                  state_nxt = IDLE;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cap_type    <= LB_MS;
         cap_qb      <= '0;
         cap_qs      <= '0;
         cap_ub      <= '0;
         cap_us      <= '0;
         rpt_r       <= '0;
         trade_cnt_r <= '0;
      end else begin
         state <= state_nxt;
         if (cap_load) begin
            cap_type <= in_type;
            cap_qb   <= sel_qb;
            cap_qs   <= sel_qs;
            cap_ub   <= sel_ub;
            cap_us   <= sel_us;
         end
         if (rpt_load)
            rpt_r <= '{trade_type: cap_type, qty: fill,
                       buy_uid: cap_ub, sell_uid: cap_us};
         if (cnt_inc)
            trade_cnt_r <= trade_cnt_r + 1'b1;
      end
   end

   assign rpt_type     = rpt_r.trade_type;
   assign rpt_qty      = rpt_r.qty;
   assign rpt_buy_uid  = rpt_r.buy_uid;
   assign rpt_sell_uid = rpt_r.sell_uid;

   always_ff @(posedge clk) begin
      if (!rst && state == WAIT && trade_vld_r)
         assert (trade_type_r != 2'd3);
   end

endmodule

// File: tb/tb_ob_cntrl_mk_exec.sv
// Directed bench for the market-order execution sequencer.
// Inputs change 1 time unit after posedge; outputs checked 1 unit later.
module tb_ob_cntrl_mk_exec;

   localparam int QW = 16;
   localparam int UW = 10;
   localparam int CW = 32;

   localparam logic [UW-1:0] UID_B  = 10'h011;
   localparam logic [UW-1:0] UID_A  = 10'h022;
   localparam logic [UW-1:0] UID_MB = 10'h033;
   localparam logic [UW-1:0] UID_MS = 10'h044;

   logic          clk = 1'b0;
   logic          rst;
   logic          en;
   logic          trade_qry;
   logic          trade_vld_r;
   logic [1:0]    trade_type_r;
   logic [QW-1:0] lm_bid_qty, lm_ask_qty, mk_buy_qty, mk_sell_qty;
   logic [UW-1:0] lm_bid_uid, lm_ask_uid, mk_buy_uid, mk_sell_uid;
   logic          lm_bid_pop, lm_ask_pop, mk_buy_pop, mk_sell_pop;
   logic          lm_bid_upd, lm_ask_upd, mk_buy_upd, mk_sell_upd;
   logic [QW-1:0] upd_qty;
   logic          rpt_vld, rpt_accept;
   logic [1:0]    rpt_type;
   logic [QW-1:0] rpt_qty;
   logic [UW-1:0] rpt_buy_uid, rpt_sell_uid;
   logic          busy;
   logic [CW-1:0] trade_cnt_r;

   logic [7:0]    strb;
   int            n_cmp = 0;
   int            n_bad = 0;
   logic [CW-1:0] exp_cnt = '0;

   always #5 clk = ~clk;

   // {lb_pop, la_pop, mb_pop, ms_pop, lb_upd, la_upd, mb_upd, ms_upd}
   assign strb = {lm_bid_pop, lm_ask_pop, mk_buy_pop, mk_sell_pop,
                  lm_bid_upd, lm_ask_upd, mk_buy_upd, mk_sell_upd};

   ob_cntrl_mk_exec #(.QTY_W(QW), .UID_W(UW), .CNT_W(CW)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .trade_qry    (trade_qry),
      .trade_vld_r  (trade_vld_r),
      .trade_type_r (trade_type_r),
      .lm_bid_qty   (lm_bid_qty),
      .lm_ask_qty   (lm_ask_qty),
      .lm_bid_uid   (lm_bid_uid),
      .lm_ask_uid   (lm_ask_uid),
      .mk_buy_qty   (mk_buy_qty),
      .mk_sell_qty  (mk_sell_qty),
      .mk_buy_uid   (mk_buy_uid),
      .mk_sell_uid  (mk_sell_uid),
      .lm_bid_pop   (lm_bid_pop),
      .lm_ask_pop   (lm_ask_pop),
      .mk_buy_pop   (mk_buy_pop),
      .mk_sell_pop  (mk_sell_pop),
      .lm_bid_upd   (lm_bid_upd),
      .lm_ask_upd   (lm_ask_upd),
      .mk_buy_upd   (mk_buy_upd),
      .mk_sell_upd  (mk_sell_upd),
      .upd_qty      (upd_qty),
      .rpt_vld      (rpt_vld),
      .rpt_accept   (rpt_accept),
      .rpt_type     (rpt_type),
      .rpt_qty      (rpt_qty),
      .rpt_buy_uid  (rpt_buy_uid),
      .rpt_sell_uid (rpt_sell_uid),
      .busy         (busy),
      .trade_cnt_r  (trade_cnt_r)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_book(input logic [QW-1:0] bq, input logic [QW-1:0] aq,
                           input logic [QW-1:0] mbq, input logic [QW-1:0] msq);
      lm_bid_qty  = bq;
      lm_ask_qty  = aq;
      mk_buy_qty  = mbq;
      mk_sell_qty = msq;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick();
      tick();
      settle();
      n_cmp++;
      if (strb !== 8'h00 || trade_qry !== 1'b0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_strobes: got strb=%h qry=%b busy=%b want 0",
                  strb, trade_qry, busy);
      end
      rst = 1'b0;
      tick();
      settle();
      n_cmp++;
      if ({rpt_vld, rpt_type, rpt_qty, rpt_buy_uid, rpt_sell_uid, upd_qty}
          !== '0 || trade_cnt_r !== '0) begin
         n_bad++;
         $display("FAIL reset_state: got vld=%b qty=%h cnt=%h want 0",
                  rpt_vld, rpt_qty, trade_cnt_r);
      end
      rpt_accept = 1'b1;
      tick();
      rpt_accept = 1'b0;
      settle();
      n_cmp++;
      if (trade_cnt_r !== '0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL idle_accept: got cnt=%h busy=%b want 0 0",
                  trade_cnt_r, busy);
      end
   endtask

   task automatic test_lb_ms();
      en = 1'b1;
      settle();
      n_cmp++;
      if (trade_qry !== 1'b1 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL lb_ms_qry: got qry=%b busy=%b want 1 0", trade_qry, busy);
      end
      tick();
      en = 1'b0;
      trade_vld_r = 1'b1;
      trade_type_r = 2'd0;
      set_book(16'd100, 16'd0, 16'd0, 16'd40);
      settle();
      n_cmp++;
      if (trade_qry !== 1'b0 || busy !== 1'b1 || strb !== 8'h00) begin
         n_bad++;
         $display("FAIL lb_ms_wait: got qry=%b busy=%b strb=%h want 0 1 00",
                  trade_qry, busy, strb);
      end
      tick();
      trade_vld_r = 1'b0;
      set_book(16'h7777, 16'h7777, 16'h7777, 16'h7777);
      settle();
      n_cmp++;
      if (strb !== 8'h18 || upd_qty !== 16'd60) begin
         n_bad++;
         $display("FAIL lb_ms_exec: got strb=%h upd=%0d want 18 60", strb, upd_qty);
      end
      tick();
      settle();
      n_cmp++;
      if (rpt_vld !== 1'b1 || rpt_qty !== 16'd40 || rpt_type !== 2'd0 ||
          rpt_buy_uid !== UID_B || rpt_sell_uid !== UID_MS || strb !== 8'h00) begin
         n_bad++;
         $display("FAIL lb_ms_rpt: got vld=%b qty=%0d type=%0d b=%h s=%h strb=%h",
                  rpt_vld, rpt_qty, rpt_type, rpt_buy_uid, rpt_sell_uid, strb);
      end
      rpt_accept = 1'b1;
      tick();
      rpt_accept = 1'b0;
      exp_cnt = exp_cnt + 1;
      settle();
      n_cmp++;
      if (rpt_vld !== 1'b0 || busy !== 1'b0 || trade_cnt_r !== exp_cnt) begin
         n_bad++;
         $display("FAIL lb_ms_done: got vld=%b busy=%b cnt=%0d want 0 0 %0d",
                  rpt_vld, busy, trade_cnt_r, exp_cnt);
      end
   endtask

   task automatic test_ms_mb_equal();
      en = 1'b1;
      tick();
      en = 1'b0;
      trade_vld_r = 1'b1;
      trade_type_r = 2'd2;
      set_book(16'd0, 16'd0, 16'd25, 16'd25);
      tick();
      trade_vld_r = 1'b0;
      settle();
      n_cmp++;
      if (strb !== 8'h30 || upd_qty !== 16'd0) begin
         n_bad++;
         $display("FAIL eq_exec: got strb=%h upd=%0d want 30 0", strb, upd_qty);
      end
      tick();
      settle();
      n_cmp++;
      if (rpt_vld !== 1'b1 || rpt_qty !== 16'd25 || rpt_type !== 2'd2 ||
          rpt_buy_uid !== UID_MB || rpt_sell_uid !== UID_MS) begin
         n_bad++;
         $display("FAIL eq_rpt: got vld=%b qty=%0d type=%0d b=%h s=%h",
                  rpt_vld, rpt_qty, rpt_type, rpt_buy_uid, rpt_sell_uid);
      end
      rpt_accept = 1'b1;
      tick();
      rpt_accept = 1'b0;
      exp_cnt = exp_cnt + 1;
      settle();
      n_cmp++;
      if (trade_cnt_r !== exp_cnt || rpt_vld !== 1'b0) begin
         n_bad++;
         $display("FAIL eq_cnt: got cnt=%0d vld=%b want %0d 0",
                  trade_cnt_r, rpt_vld, exp_cnt);
      end
   endtask

   task automatic test_ls_mb_stall();
      en = 1'b1;
      tick();
      trade_vld_r = 1'b1;
      trade_type_r = 2'd1;
      set_book(16'd0, 16'd30, 16'd50, 16'd0);
      tick();
      trade_vld_r = 1'b0;
      settle();
      n_cmp++;
      if (strb !== 8'h42 || upd_qty !== 16'd20 || trade_qry !== 1'b0) begin
         n_bad++;
         $display("FAIL stall_exec: got strb=%h upd=%0d qry=%b want 42 20 0",
                  strb, upd_qty, trade_qry);
      end
      for (int i = 0; i < 5; i++) begin
         tick();
         settle();
         n_cmp++;
         if (rpt_vld !== 1'b1 || rpt_qty !== 16'd30 || rpt_type !== 2'd1 ||
             rpt_buy_uid !== UID_MB || rpt_sell_uid !== UID_A ||
             trade_qry !== 1'b0 || strb !== 8'h00) begin
            n_bad++;
            $display("FAIL stall_hold%0d: got vld=%b qty=%0d b=%h s=%h qry=%b",
                     i, rpt_vld, rpt_qty, rpt_buy_uid, rpt_sell_uid, trade_qry);
         end
      end
      tick();
      rpt_accept = 1'b1;
      settle();
      n_cmp++;
      if (rpt_vld !== 1'b1 || trade_cnt_r !== exp_cnt) begin
         n_bad++;
         $display("FAIL stall_last: got vld=%b cnt=%0d want 1 %0d",
                  rpt_vld, trade_cnt_r, exp_cnt);
      end
      tick();
      rpt_accept = 1'b0;
      en = 1'b0;
      exp_cnt = exp_cnt + 1;
      settle();
      n_cmp++;
      if (rpt_vld !== 1'b0 || trade_cnt_r !== exp_cnt || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL stall_done: got vld=%b cnt=%0d busy=%b want 0 %0d 0",
                  rpt_vld, trade_cnt_r, busy, exp_cnt);
      end
   endtask

   task automatic test_no_decision();
      en = 1'b1;
      tick();
      trade_vld_r = 1'b0;
      trade_type_r = 2'd0;
      set_book(16'd9, 16'd9, 16'd9, 16'd9);
      settle();
      n_cmp++;
      if (busy !== 1'b1 || strb !== 8'h00) begin
         n_bad++;
         $display("FAIL nodec_wait: got busy=%b strb=%h want 1 00", busy, strb);
      end
      tick();
      settle();
      n_cmp++;
      if (busy !== 1'b0 || trade_qry !== 1'b1 || strb !== 8'h00 ||
          trade_cnt_r !== exp_cnt) begin
         n_bad++;
         $display("FAIL nodec_idle: got busy=%b qry=%b strb=%h cnt=%0d",
                  busy, trade_qry, strb, trade_cnt_r);
      end
      tick();
      en = 1'b0;
      tick();
      settle();
      n_cmp++;
      if (busy !== 1'b0 || trade_qry !== 1'b0 || strb !== 8'h00) begin
         n_bad++;
         $display("FAIL nodec_back: got busy=%b qry=%b strb=%h want 0 0 00",
                  busy, trade_qry, strb);
      end
   endtask

   task automatic test_zero_qty();
      en = 1'b1;
      tick();
      en = 1'b0;
      trade_vld_r = 1'b1;
      trade_type_r = 2'd2;
      set_book(16'd0, 16'd0, 16'd0, 16'd40);
      tick();
      trade_vld_r = 1'b0;
      settle();
      n_cmp++;
      if (strb !== 8'h20 || upd_qty !== 16'd0) begin
         n_bad++;
         $display("FAIL zero_exec: got strb=%h upd=%0d want 20 0", strb, upd_qty);
      end
      tick();
      settle();
      n_cmp++;
      if (rpt_vld !== 1'b0 || busy !== 1'b0 || trade_cnt_r !== exp_cnt) begin
         n_bad++;
         $display("FAIL zero_done: got vld=%b busy=%b cnt=%0d want 0 0 %0d",
                  rpt_vld, busy, trade_cnt_r, exp_cnt);
      end
   endtask

   task automatic test_back_to_back();
      en = 1'b1;
      tick();
      trade_vld_r = 1'b1;
      trade_type_r = 2'd2;
      set_book(16'd0, 16'd0, 16'd10, 16'd7);
      tick();
      trade_vld_r = 1'b0;
      settle();
      n_cmp++;
      if (strb !== 8'h12 || upd_qty !== 16'd3) begin
         n_bad++;
         $display("FAIL b2b_exec1: got strb=%h upd=%0d want 12 3", strb, upd_qty);
      end
      tick();
      rpt_accept = 1'b1;
      settle();
      n_cmp++;
      if (rpt_vld !== 1'b1 || rpt_qty !== 16'd7) begin
         n_bad++;
         $display("FAIL b2b_rpt1: got vld=%b qty=%0d want 1 7", rpt_vld, rpt_qty);
      end
      tick();
      rpt_accept = 1'b0;
      exp_cnt = exp_cnt + 1;
      settle();
      n_cmp++;
      if (trade_qry !== 1'b1 || trade_cnt_r !== exp_cnt) begin
         n_bad++;
         $display("FAIL b2b_requery: got qry=%b cnt=%0d want 1 %0d",
                  trade_qry, trade_cnt_r, exp_cnt);
      end
      tick();
      en = 1'b0;
      trade_vld_r = 1'b1;
      trade_type_r = 2'd0;
      set_book(16'd5, 16'd0, 16'd0, 16'd5);
      tick();
      trade_vld_r = 1'b0;
      settle();
      n_cmp++;
      if (strb !== 8'h90 || upd_qty !== 16'd0) begin
         n_bad++;
         $display("FAIL b2b_exec2: got strb=%h upd=%0d want 90 0", strb, upd_qty);
      end
      tick();
      rpt_accept = 1'b1;
      settle();
      n_cmp++;
      if (rpt_vld !== 1'b1 || rpt_qty !== 16'd5 || rpt_buy_uid !== UID_B ||
          rpt_sell_uid !== UID_MS) begin
         n_bad++;
         $display("FAIL b2b_rpt2: got vld=%b qty=%0d b=%h s=%h",
                  rpt_vld, rpt_qty, rpt_buy_uid, rpt_sell_uid);
      end
      tick();
      rpt_accept = 1'b0;
      exp_cnt = exp_cnt + 1;
      settle();
      n_cmp++;
      if (trade_cnt_r !== exp_cnt || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL b2b_cnt: got cnt=%0d busy=%b want %0d 0",
                  trade_cnt_r, busy, exp_cnt);
      end
   endtask

   task automatic test_reset_mid();
      en = 1'b1;
      tick();
      en = 1'b0;
      trade_vld_r = 1'b1;
      trade_type_r = 2'd2;
      set_book(16'd0, 16'd0, 16'd9, 16'd9);
      tick();
      trade_vld_r = 1'b0;
      tick();
      rst = 1'b1;
      settle();
      n_cmp++;
      if (rpt_vld !== 1'b0 || busy !== 1'b0 || strb !== 8'h00) begin
         n_bad++;
         $display("FAIL rst_emit_cyc: got vld=%b busy=%b strb=%h want 0 0 00",
                  rpt_vld, busy, strb);
      end
      tick();
      rst = 1'b0;
      exp_cnt = '0;
      settle();
      n_cmp++;
      if (rpt_vld !== 1'b0 || busy !== 1'b0 || trade_cnt_r !== exp_cnt ||
          rpt_qty !== 16'd0 || strb !== 8'h00) begin
         n_bad++;
         $display("FAIL rst_emit_after: got vld=%b busy=%b cnt=%0d qty=%0d",
                  rpt_vld, busy, trade_cnt_r, rpt_qty);
      end
      en = 1'b1;
      tick();
      en = 1'b0;
      trade_vld_r = 1'b1;
      trade_type_r = 2'd0;
      set_book(16'd8, 16'd0, 16'd0, 16'd3);
      tick();
      trade_vld_r = 1'b0;
      rst = 1'b1;
      settle();
      n_cmp++;
      if (strb !== 8'h00 || upd_qty !== 16'd0 || busy !== 1'b0) begin
         n_bad++;
         $display("FAIL rst_exec_cyc: got strb=%h upd=%0d busy=%b want 00 0 0",
                  strb, upd_qty, busy);
      end
      tick();
      rst = 1'b0;
      tick();
      settle();
      n_cmp++;
      if (busy !== 1'b0 || rpt_vld !== 1'b0 || strb !== 8'h00 ||
          trade_cnt_r !== exp_cnt) begin
         n_bad++;
         $display("FAIL rst_exec_after: got busy=%b vld=%b strb=%h cnt=%0d",
                  busy, rpt_vld, strb, trade_cnt_r);
      end
   endtask

   initial begin
      rst = 1'b1;
      en = 1'b0;
      trade_vld_r = 1'b0;
      trade_type_r = 2'd0;
      rpt_accept = 1'b0;
      lm_bid_uid = UID_B;
      lm_ask_uid = UID_A;
      mk_buy_uid = UID_MB;
      mk_sell_uid = UID_MS;
      set_book(16'd0, 16'd0, 16'd0, 16'd0);
      test_reset();
      test_lb_ms();
      test_ms_mb_equal();
      test_ls_mb_stall();
      test_no_decision();
      test_zero_qty();
      test_back_to_back();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/ob_cntrl_mk_exec.md
Name: ob_cntrl_mk_exec

Overview:
- Sequencer for the market-order trade-decision stage. Issues the trade query, captures the registered decision, computes fill quantity and residuals, then drives pop/update strobes to the limit tables and market queues.
- Emits one trade report per executed trade over a valid/accept handshake.
- Sits between the market-order decision logic and the order-book tables/queues. One trade at a time, never pipelined.

Parameters:
- QTY_W, 16, width of order quantity fields
- UID_W, 10, width of order UID fields
- CNT_W, 32, width of executed-trade statistics counter

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- en  in  1  permits launching new queries; sampled in IDLE only
- trade_qry  out  1  one-cycle query strobe to the decision stage
- trade_vld_r  in  1  registered decision valid, arrives 1 cycle after trade_qry
- trade_type_r  in  2  0=LB_MS, 1=LS_MB, 2=MS_MB, 3=reserved
- lm_bid_qty, lm_ask_qty  in  QTY_W  head limit bid/ask quantities
- lm_bid_uid, lm_ask_uid  in  UID_W  head limit bid/ask UIDs
- mk_buy_qty, mk_sell_qty  in  QTY_W  head market buy/sell quantities
- mk_buy_uid, mk_sell_uid  in  UID_W  head market buy/sell UIDs
- lm_bid_pop, lm_ask_pop, mk_buy_pop, mk_sell_pop  out  1  remove head entry (one-cycle pulse)
- lm_bid_upd, lm_ask_upd, mk_buy_upd, mk_sell_upd  out  1  overwrite head quantity (one-cycle pulse)
- upd_qty  out  QTY_W  residual quantity accompanying the active *_upd
- rpt_vld  out  1  trade report valid
- rpt_accept  in  1  trade report accepted
- rpt_type  out  2  executed trade type
- rpt_qty  out  QTY_W  filled quantity
- rpt_buy_uid, rpt_sell_uid  out  UID_W  counterparties
- busy  out  1  FSM not in IDLE
- trade_cnt_r  out  CNT_W  executed trades since reset; wraps at 2^CNT_W

Behaviour:
- Reset: FSM=IDLE. trade_qry, all pop/upd, rpt_vld and busy are 0. upd_qty, rpt_* and trade_cnt_r are 0. Reset mid-operation aborts the trade immediately; no strobes are issued in the reset cycle.
- IDLE: if en, assert trade_qry for 1 cycle and go to WAIT. Otherwise stay.
- WAIT (1 cycle): if trade_vld_r=0, return to IDLE with no side effects.
  - If trade_type_r=3, return to IDLE with no side effects; a simulation assertion fires.
  - Otherwise capture the type and the two sides' qty/uid and go to EXEC. Side pairs are: LB_MS (bid, mk_sell), LS_MB (ask, mk_buy), MS_MB (mk_buy, mk_sell).
- EXEC (1 cycle):
  - fill = min(qb, qs), where qb/qs are the buy-side/sell-side quantities.
  - Side with the smaller quantity: pop. Side with the larger quantity: upd with upd_qty = larger − fill. If equal, both pop and no upd.
  - Compare is unsigned at QTY_W; the residual never underflows.
  - A zero-quantity side is popped with fill=0 and no report is generated; go to IDLE.
  - Otherwise load rpt_* and go to EMIT.
- EMIT: rpt_vld=1, with rpt_* held stable until rpt_accept.
  - On rpt_vld & rpt_accept: trade_cnt_r += 1, rpt_vld drops next cycle, go to IDLE.
  - rpt_accept while not in EMIT is ignored.
- Latency: query-to-strobe is 2 cycles. Query-to-rpt_vld is 3 cycles. Minimum inter-query spacing is 4 cycles (accept in the first EMIT cycle).
- At most one pop/upd pair is active per EXEC cycle. Strobes are never asserted outside EXEC.
- en deasserted mid-trade does not abort; it only blocks the next query.
- busy = (state != IDLE).

Decomposition:
- Shared package ob_pkg gets:
  - trade_type_t enum (LB_MS, LS_MB, MS_MB, RSVD)
  - exec_state_t enum (IDLE, WAIT, EXEC, EMIT)
  - exec_rpt_t struct (type, qty, buy_uid, sell_uid)
- Sub-module ob_fill_calc: purely combinational min/residual/equal calculator (qb, qs -> fill, buy_pop, sell_pop, buy_upd, sell_upd, resid). Instantiated once in EXEC.

Test Plan:
- LB_MS, bid=100, mk_sell=40 -> mk_sell_pop, lm_bid_upd with upd_qty=60; report qty=40; trade_cnt_r 0->1.
- MS_MB, buy=25, sell=25 -> mk_buy_pop and mk_sell_pop in the same cycle, no upd; report qty=25.
- LS_MB with rpt_accept held low 5 cycles -> rpt_vld high 5+ cycles, rpt_* stable, no new trade_qry until accept.
- trade_vld_r=0 in WAIT -> FSM back to IDLE, no strobes, trade_cnt_r unchanged; next query issued if en=1.
- rst asserted during EMIT -> next cycle rpt_vld=0, busy=0, trade_cnt_r=0, no strobes.
- mk_buy_qty=0 on MS_MB -> mk_buy_pop only, no report, back to IDLE.
